// File: rtl/can_tx_frame_sequencer_pkg.sv
// Shared types and constants for the CAN TX frame sequencer.
// Holds the FSM encoding, the packed frame word (98 bits), CMD-word bit positions,
// the OPB read latency and helpers that build the ID and CMD register words.
package can_tx_frame_sequencer_pkg;

  localparam int FRAME_W       = 98;  // ide + id[28:0] + dlc[3:0] + data[63:0]
  localparam int OPB_RD_LAT    = 2;   // cycles from RE strobe to valid OPB_DI
  localparam int CMD_TXREQ_BIT = 0;   // transmit-request bit in CMD word
  localparam int CMD_DLC_LSB   = 4;   // clamped DLC sits in CMD[7:4]
  localparam int POLL_CNT_W    = 16;  // saturating status-poll counter

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_GAP,
    ST_WR_ID,
    ST_WR_D0,
    ST_WR_D1,
    ST_WR_CMD,
    ST_DONE,
    ST_ABORT
  } seq_state_e;

  typedef struct packed {
    logic        ide;
    logic [28:0] id;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  // Extended IDs go out whole; standard IDs keep only the 11 low bits.
  function automatic logic [31:0] id_word(input frame_t f);
    if (f.ide) return {1'b1, 2'b00, f.id};
    else       return {1'b0, 2'b00, 18'd0, f.id[10:0]};
  endfunction

  function automatic logic [3:0] dlc_clamp(input logic [3:0] dlc);
    return (dlc > 4'd8) ? 4'd8 : dlc;
  endfunction

  function automatic logic [31:0] cmd_word(input frame_t f);
    logic [31:0] w;
    w = '0;
    w[CMD_DLC_LSB +: 4] = dlc_clamp(f.dlc);
    w[CMD_TXREQ_BIT]    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/can_tx_frame_sequencer_if.sv
// Host frame handshake plus OPB master bus, bundled for the sequencer.
// Ports: frm_valid/frm_ready/frm_id/frm_ide/frm_dlc/frm_data (host side),
//        OPB_ADDR/OPB_DO/OPB_DI/OPB_WE/OPB_RE (wrapper side).
// master = sequencer view, slave = host/wrapper environment view.
interface can_tx_frame_sequencer_if;

  logic        frm_valid;
  logic        frm_ready;
  logic [28:0] frm_id;
  logic        frm_ide;
  logic [3:0]  frm_dlc;
  logic [63:0] frm_data;

  logic [31:0] OPB_ADDR;
  logic [31:0] OPB_DO;
  logic [31:0] OPB_DI;
  logic        OPB_WE;
  logic        OPB_RE;

  modport master (
    input  frm_valid, frm_id, frm_ide, frm_dlc, frm_data, OPB_DI,
    output frm_ready, OPB_ADDR, OPB_DO, OPB_WE, OPB_RE
  );

  modport slave (
    output frm_valid, frm_id, frm_ide, frm_dlc, frm_data, OPB_DI,
    input  frm_ready, OPB_ADDR, OPB_DO, OPB_WE, OPB_RE
  );

endinterface

// File: rtl/can_tx_frame_sequencer_fifo.sv
// Synchronous frame FIFO (WIDTH x DEPTH, DEPTH a power of two) with occupancy output.
// Latency: pushed word visible at rd_dat the cycle after push; level updates same edge.
// Backpressure: full when level==DEPTH; a push while full is taken only alongside a pop.
// Ports: clk, rst_n (sync, active low), push/wr_dat, pop, rd_dat (head), full, empty, level.
module can_tx_frame_fifo #(
  parameter int WIDTH = 98,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_dat  = mem[rd_ptr];

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/can_tx_frame_sequencer.sv
// OPB master that buffers host CAN TX frames and writes each into the CAN wrapper
// (poll STAT until TX buffer free, then ID, DATA0, DATA1, CMD) with an idle gap after every access.
// Latency: 1+2+5*(GAP_CYCLES+1) cycles IDLE->tx_done when free on the first poll.
// Backpressure: frm_ready = FIFO not full; a frame stays at the FIFO head until done or aborted.
// Ports: OPB_CLK, OPB_RST_N (sync, active low); io (master modport: host frame handshake
//        and OPB bus); tx_done / tx_err one-cycle pulses; fifo_level occupancy.
// Build option: CAN_TXSEQ_RETRY_EN adds up to RETRY_MAX full polling rounds before tx_err.
module can_tx_frame_sequencer
  import can_tx_frame_sequencer_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 4,
  parameter int          GAP_CYCLES   = 4,
  parameter int          POLL_TIMEOUT = 1024,
  parameter logic [31:0] ADDR_STAT    = 32'h0000_8010,
  parameter logic [31:0] ADDR_ID      = 32'h0000_0010,
  parameter logic [31:0] ADDR_D0      = 32'h0000_0014,
  parameter logic [31:0] ADDR_D1      = 32'h0000_0018,
  parameter logic [31:0] ADDR_CMD     = 32'h0000_001C,
  parameter int          FREE_BIT     = 0
`ifdef CAN_TXSEQ_RETRY_EN
  ,
  parameter int          RETRY_MAX    = 3
`endif
) (
  input  logic                        OPB_CLK,
  input  logic                        OPB_RST_N,
  can_tx_frame_sequencer_if.master    io,
  output logic                        tx_done,
  output logic                        tx_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int               CNT_W    = 16;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(OPB_RD_LAT - 1);

  seq_state_e             state_q, state_d;
  seq_state_e             gap_ret_q, gap_ret_d;  // where the current gap leads
  logic [CNT_W-1:0]       cnt_q, cnt_d;          // shared by read wait and gap
  logic [POLL_CNT_W-1:0]  polls_q, polls_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            wdat_q, wdat_d;
  logic                   gap_go;
`ifdef CAN_TXSEQ_RETRY_EN
  logic [7:0]             retry_q, retry_d;
`endif

  frame_t in_frame;
  frame_t head;
  logic   fifo_push;
  logic   fifo_pop;
  logic   fifo_full;
  logic   fifo_empty;
  logic   unused_di;

  // Only the FREE bit of the status word is acted on.
  assign unused_di = ^io.OPB_DI;

  assign in_frame     = {io.frm_ide, io.frm_id, io.frm_dlc, io.frm_data};
  assign io.frm_ready = ~fifo_full;
  assign fifo_push    = io.frm_valid & io.frm_ready;

  can_tx_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (OPB_CLK),
    .rst_n  (OPB_RST_N),
    .push   (fifo_push),
    .wr_dat (in_frame),
    .pop    (fifo_pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Strobes and pulses decode straight from the registered state.
  assign io.OPB_RE   = (state_q == ST_POLL_RD);
  assign io.OPB_WE   = (state_q == ST_WR_ID) || (state_q == ST_WR_D0) ||
                       (state_q == ST_WR_D1) || (state_q == ST_WR_CMD);
  assign io.OPB_ADDR = addr_q;
  assign io.OPB_DO   = wdat_q;
  assign tx_done     = (state_q == ST_DONE);
  assign tx_err      = (state_q == ST_ABORT);

  always_comb begin
    state_d   = state_q;
    gap_ret_d = gap_ret_q;
    cnt_d     = cnt_q;
    polls_d   = polls_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    gap_go    = 1'b0;
    fifo_pop  = 1'b0;
`ifdef CAN_TXSEQ_RETRY_EN
    retry_d   = retry_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          polls_d = '0;
`ifdef CAN_TXSEQ_RETRY_EN
          retry_d = '0;
`endif
          addr_d  = ADDR_STAT;
          state_d = ST_POLL_RD;
        end
      end

      ST_POLL_RD: begin
        if (polls_q != '1) polls_d = polls_q + 1'b1;
        cnt_d   = RD_LOAD;
        state_d = ST_POLL_WAIT;
      end

      // Status is sampled on the last wait cycle, OPB_RD_LAT cycles after RE.
      ST_POLL_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (io.OPB_DI[FREE_BIT]) begin
          gap_go    = 1'b1;
          gap_ret_d = ST_WR_ID;
        end else if (32'(polls_q) < POLL_TIMEOUT) begin
          gap_go    = 1'b1;
          gap_ret_d = ST_POLL_RD;
`ifdef CAN_TXSEQ_RETRY_EN
        end else if (32'(retry_q) < RETRY_MAX) begin
          retry_d   = retry_q + 1'b1;
          polls_d   = '0;
          gap_go    = 1'b1;
          gap_ret_d = ST_POLL_RD;
`endif
        end else begin
          state_d = ST_ABORT;
        end
      end

      // Address/data for the next access load as the gap ends, so they are
      // already stable in the strobe cycle and hold afterwards.
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = gap_ret_q;
          unique case (gap_ret_q)
            ST_POLL_RD: addr_d = ADDR_STAT;
            ST_WR_ID:  begin addr_d = ADDR_ID;  wdat_d = id_word(head);  end
            ST_WR_D0:  begin addr_d = ADDR_D0;  wdat_d = head.data[31:0];  end
            ST_WR_D1:  begin addr_d = ADDR_D1;  wdat_d = head.data[63:32]; end
            ST_WR_CMD: begin addr_d = ADDR_CMD; wdat_d = cmd_word(head); end
            default: ;
          endcase
        end
      end

      ST_WR_ID:  begin gap_go = 1'b1; gap_ret_d = ST_WR_D0;  end
      ST_WR_D0:  begin gap_go = 1'b1; gap_ret_d = ST_WR_D1;  end
      ST_WR_D1:  begin gap_go = 1'b1; gap_ret_d = ST_WR_CMD; end
      ST_WR_CMD: begin gap_go = 1'b1; gap_ret_d = ST_DONE;   end

      ST_DONE, ST_ABORT: begin
        fifo_pop = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    if (gap_go) begin
      state_d = ST_GAP;
      cnt_d   = GAP_LOAD;
    end
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      state_q   <= ST_IDLE;
      gap_ret_q <= ST_IDLE;
      cnt_q     <= '0;
      polls_q   <= '0;
      addr_q    <= '0;
      wdat_q    <= '0;
`ifdef CAN_TXSEQ_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gap_ret_q <= gap_ret_d;
      cnt_q     <= cnt_d;
      polls_q   <= polls_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
`ifdef CAN_TXSEQ_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_can_tx_frame_sequencer.sv
// Bench for can_tx_frame_sequencer: table of frames with hand-computed register words,
// plus sequences for status polling, timeout, FIFO backpressure and mid-frame reset.
// A negedge monitor logs OPB writes/reads and models the wrapper status register.
module tb_can_tx_frame_sequencer;

  localparam int GAP_CYCLES   = 4;
  localparam int POLL_TIMEOUT = 1024;
`ifdef CAN_TXSEQ_RETRY_EN
  localparam int RETRY_MAX    = 3;
  localparam int EXP_POLLS    = POLL_TIMEOUT * (1 + RETRY_MAX);
`else
  localparam int EXP_POLLS    = POLL_TIMEOUT;
`endif
  localparam int EXP_LAT      = 1 + (1 + 2 + 5 * (GAP_CYCLES + 1));
  localparam int RE_SPACING   = 2 + GAP_CYCLES + 1;

  logic clk;
  logic rst_n;
  logic tx_done;
  logic tx_err;
  logic [2:0] fifo_level;

  can_tx_frame_sequencer_if bus ();

  can_tx_frame_sequencer dut (
    .OPB_CLK    (clk),
    .OPB_RST_N  (rst_n),
    .io         (bus),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .fifo_level (fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int re_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int bad_rd_addr = 0;
  int zero_polls = 0;   // number of leading polls answered "busy"
  int accept_cyc = 0;
  int done_cyc = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          re_cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper model: poll k answers FREE only when k > zero_polls.
  always @(negedge clk) begin
    if (bus.OPB_WE) begin
      wr_addr_q.push_back(bus.OPB_ADDR);
      wr_data_q.push_back(bus.OPB_DO);
    end
    if (bus.OPB_RE) begin
      re_cnt = re_cnt + 1;
      re_cyc_q.push_back(cyc);
      if (bus.OPB_ADDR != 32'h8010) bad_rd_addr = bad_rd_addr + 1;
    end
    if (tx_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (tx_err) err_cnt = err_cnt + 1;
    if (bus.frm_valid && bus.frm_ready) accept_cyc = cyc;
    bus.OPB_DI = (re_cnt > zero_polls) ? 32'h1 : 32'h0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete();
    wr_data_q.delete();
    re_cyc_q.delete();
    re_cnt   = 0;
    done_cnt = 0;
    err_cnt  = 0;
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic push(input logic [28:0] id, input logic ide, input logic [3:0] dlc,
                      input logic [63:0] data);
    bit ok;
    ok = 1'b0;
    bus.frm_valid = 1'b1;
    bus.frm_id    = id;
    bus.frm_ide   = ide;
    bus.frm_dlc   = dlc;
    bus.frm_data  = data;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = bus.frm_ready;
    end
    step();
    check("push_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget && done_cnt < n; i++) @(negedge clk);
    check("tx_done_count", done_cnt, n);
  endtask

  typedef struct {
    logic [28:0] id;
    logic        ide;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [31:0] e_id;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [31:0] e_cmd;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] exp_addr [4];
  logic [31:0] exp_data [4];
  int          n_wr;
  int          lvl_before;

  initial begin
    vecs[0] = '{29'h123,        1'b0, 4'd8,  64'h0807060504030201,
                32'h00000123, 32'h04030201, 32'h08070605, 32'h00000081};
    vecs[1] = '{29'h1ABCDEF0,   1'b1, 4'd12, 64'h1122334455667788,
                32'h9ABCDEF0, 32'h55667788, 32'h11223344, 32'h00000081};
    vecs[2] = '{29'h7FF,        1'b0, 4'd0,  64'h0,
                32'h000007FF, 32'h00000000, 32'h00000000, 32'h00000001};
    vecs[3] = '{29'h1FFFFABC,   1'b0, 4'd3,  64'hDEADBEEFCAFEF00D,
                32'h000002BC, 32'hCAFEF00D, 32'hDEADBEEF, 32'h00000031};
    vecs[4] = '{29'h1,          1'b1, 4'd15, 64'hFFFFFFFF00000000,
                32'h80000001, 32'h00000000, 32'hFFFFFFFF, 32'h00000081};
    vecs[5] = '{29'h1FFFFFFF,   1'b1, 4'd9,  64'h0123456789ABCDEF,
                32'h9FFFFFFF, 32'h89ABCDEF, 32'h01234567, 32'h00000081};
    exp_addr = '{32'h10, 32'h14, 32'h18, 32'h1C};

    rst_n         = 1'b0;
    bus.frm_valid = 1'b0;
    bus.frm_id    = '0;
    bus.frm_ide   = 1'b0;
    bus.frm_dlc   = '0;
    bus.frm_data  = '0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_we",    32'(bus.OPB_WE), 32'd0);
    check("rst_re",    32'(bus.OPB_RE), 32'd0);
    check("rst_addr",  bus.OPB_ADDR,    32'd0);
    check("rst_do",    bus.OPB_DO,      32'd0);
    check("rst_done",  32'(tx_done),    32'd0);
    check("rst_err",   32'(tx_err),     32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(bus.frm_ready), 32'd1);

    // Table: one frame each, status free on first poll.
    zero_polls = 0;
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      step();
      push(vecs[v].id, vecs[v].ide, vecs[v].dlc, vecs[v].data);
      bus.frm_valid = 1'b0;
      wait_done(1, 200);
      if (v == 0) check("min_latency", done_cyc - accept_cyc, EXP_LAT);
      check("wr_count", wr_addr_q.size(), 4);
      check("re_count", re_cnt, 1);
      exp_data = '{vecs[v].e_id, vecs[v].e_d0, vecs[v].e_d1, vecs[v].e_cmd};
      if (wr_addr_q.size() == 4) begin
        for (int j = 0; j < 4; j++) begin
          check($sformatf("v%0d_addr%0d", v, j), wr_addr_q[j], exp_addr[j]);
          check($sformatf("v%0d_data%0d", v, j), wr_data_q[j], exp_data[j]);
        end
      end
    end

    // Five busy polls then free: six RE strobes at fixed spacing.
    clear_logs();
    zero_polls = 5;
    step();
    push(29'h55, 1'b0, 4'd2, 64'hAABB);
    bus.frm_valid = 1'b0;
    wait_done(1, 400);
    check("poll_re_count", re_cyc_q.size(), 6);
    for (int i = 1; i < re_cyc_q.size(); i++)
      check($sformatf("poll_spacing%0d", i), re_cyc_q[i] - re_cyc_q[i-1], RE_SPACING);
    check("poll_wr_count", wr_addr_q.size(), 4);
    if (wr_data_q.size() >= 4) begin
      check("poll_id", wr_data_q[0], 32'h55);
      check("poll_cmd", wr_data_q[3], 32'h21);
    end

    // Five frames back-to-back against a 4-deep FIFO.
    clear_logs();
    zero_polls = 0;
    step();
    for (int f = 0; f < 4; f++) push(29'h40 + 29'(f), 1'b0, 4'd1, 64'(f));
    @(negedge clk);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(bus.frm_ready), 32'd0);
    step();
    push(29'h44, 1'b0, 4'd1, 64'd4);
    bus.frm_valid = 1'b0;
    wait_done(5, 400);
    check("burst_wr_count", wr_addr_q.size(), 20);
    if (wr_addr_q.size() == 20) begin
      for (int f = 0; f < 5; f++) begin
        check($sformatf("burst_id_addr%0d", f), wr_addr_q[4*f], 32'h10);
        check($sformatf("burst_id%0d", f), wr_data_q[4*f], 32'h40 + f);
        check($sformatf("burst_d0_%0d", f), wr_data_q[4*f+1], 32'(f));
      end
    end
    check("burst_level", 32'(fifo_level), 32'd0);

    // Status never free: frame dropped after the poll budget.
    clear_logs();
    zero_polls = 32'h4000_0000;
    step();
    push(29'h77, 1'b0, 4'd8, 64'h1);
    bus.frm_valid = 1'b0;
    for (int i = 0; i < EXP_POLLS * RE_SPACING + 200 && err_cnt == 0; i++) @(negedge clk);
    check("timeout_err", err_cnt, 1);
    check("timeout_polls", re_cnt, EXP_POLLS);
    check("timeout_writes", wr_addr_q.size(), 0);
    check("timeout_done", done_cnt, 0);
    @(negedge clk);
    check("timeout_level", 32'(fifo_level), 32'd0);

    // Reset in the gap between the ID and DATA0 writes.
    clear_logs();
    zero_polls = 0;
    step();
    push(29'h66, 1'b0, 4'd8, 64'h5);
    push(29'h67, 1'b0, 4'd8, 64'h6);
    bus.frm_valid = 1'b0;
    for (int i = 0; i < 100 && wr_addr_q.size() == 0; i++) @(negedge clk);
    check("rst_seq_idwr", wr_addr_q.size(), 1);
    lvl_before = int'(fifo_level);
    check("rst_seq_lvl_before", lvl_before, 2);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_seq_level", 32'(fifo_level), 32'd0);
    check("rst_seq_ready", 32'(bus.frm_ready), 32'd1);
    check("rst_seq_addr", bus.OPB_ADDR, 32'd0);
    n_wr = wr_addr_q.size();
    repeat (60) @(negedge clk);
    check("rst_seq_no_wr", wr_addr_q.size(), n_wr);
    check("rst_seq_no_re", re_cnt, 1);
    check("rst_seq_no_done", done_cnt, 0);

    check("stat_rd_addr", bad_rd_addr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
